// File: rtl/conversor_bin_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// A start/done handshake (inicio/pronto) requests and reports one conversion at a time.
module conversor_bin_bcd_seq #(
  parameter int LARGURA_BIN = 8,
  parameter int DIGITOS     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inicio,
  input  logic [LARGURA_BIN-1:0] Entrada,
  output logic [4*DIGITOS-1:0]   Saida,
  output logic                   ocupado,
  output logic                   pronto,
  output logic                   estouro
);

  localparam int BW = 4 * DIGITOS;
  localparam int CW = $clog2(LARGURA_BIN + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(LARGURA_BIN - 1);

  typedef enum logic [1:0] {OCIOSO, CONVERTE, CONCLUI} estado_t;

  estado_t                estado, prox_estado;
  logic [LARGURA_BIN-1:0] desl_bin;
  logic [BW-1:0]          desl_bcd;
  logic [BW-1:0]          adj_bcd;
  logic [BW-1:0]          novo_bcd;
  logic [CW-1:0]          contador;
  logic                   ovf;
  logic                   bit_saida;
  logic                   aceita;
  logic                   fim;

  // One add-3 cell per digit; digits are independent, carries move only via the shift.
  always_comb begin
    adj_bcd = desl_bcd;
    for (int unsigned i = 0; i < DIGITOS; i++) begin
      if (desl_bcd[4*i +: 4] >= 4'd5)
        adj_bcd[4*i +: 4] = desl_bcd[4*i +: 4] + 4'd3;
    end
    novo_bcd  = {adj_bcd[BW-2:0], desl_bin[LARGURA_BIN-1]};
    bit_saida = adj_bcd[BW-1];
  end

  always_comb begin
    prox_estado = estado;
    aceita      = 1'b0;
    fim         = 1'b0;
    case (estado)
      OCIOSO: begin
        aceita = inicio;
        if (inicio) prox_estado = CONVERTE;
      end
      CONVERTE: begin
        fim = (contador == ULTIMO);
        if (fim) prox_estado = CONCLUI;
      end
      CONCLUI: begin
        aceita      = inicio;
        prox_estado = inicio ? CONVERTE : OCIOSO;
      end
      default: prox_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) estado <= OCIOSO;
    else       estado <= prox_estado;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      desl_bin <= '0;
      desl_bcd <= '0;
      contador <= '0;
      ovf      <= 1'b0;
      Saida    <= '0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
      estouro  <= 1'b0;
    end else begin
      pronto <= 1'b0;
      if (aceita) begin
        desl_bin <= Entrada;
        desl_bcd <= '0;
        contador <= '0;
        ovf      <= 1'b0;
        estouro  <= 1'b0;
        ocupado  <= 1'b1;
      end else if (estado == CONVERTE) begin
        desl_bcd <= novo_bcd;
        desl_bin <= desl_bin << 1;
        ovf      <= ovf | bit_saida;
        contador <= contador + CW'(1);
        if (fim) begin
          Saida   <= novo_bcd;
          estouro <= ovf | bit_saida;
          pronto  <= 1'b1;
          ocupado <= 1'b0;
        end
      end
    end
  end

endmodule
